// File: rtl/mnist_pkg.sv
// Shared constants and state encoding for the MNIST classifier back end.
package mnist_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 32;
    localparam int IDX_W       = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/mnist_signed_max_cmp.sv
// Signed strict-greater compare and select of a candidate against the running best.
// Ties keep the incumbent, so the earliest (lowest) index wins.
module mnist_signed_max_cmp #(
    parameter int DATA_W = mnist_pkg::DATA_W,
    parameter int IDX_W  = mnist_pkg::IDX_W
) (
    input  logic [DATA_W-1:0] best_score,
    input  logic [IDX_W-1:0]  best_idx,
    input  logic [DATA_W-1:0] cand_score,
    input  logic [IDX_W-1:0]  cand_idx,
    output logic [DATA_W-1:0] next_score,
    output logic [IDX_W-1:0]  next_idx
);

    logic cand_wins;

    assign cand_wins  = $signed(cand_score) > $signed(best_score);
    assign next_score = cand_wins ? cand_score : best_score;
    assign next_idx   = cand_wins ? cand_idx   : best_idx;

endmodule

// File: rtl/mnist_argmax_classifier.sv
// Streaming argmax over NUM_CLASSES signed logits, one result pulse per frame.
// Define MNIST_ARGMAX_TIMEOUT_EN to drop frames that stall longer than TIMEOUT_CYCLES.
module mnist_argmax_classifier #(
    parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
    parameter int DATA_W      = mnist_pkg::DATA_W,
    parameter int IDX_W       = mnist_pkg::IDX_W,
    parameter int CNT_W       = 16
`ifdef MNIST_ARGMAX_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              logit_valid,
    input  logic [DATA_W-1:0] logit_in,
    input  logic              frame_start,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic              class_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              err
);

    import mnist_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  best_idx;
    logic [DATA_W-1:0] best_score;
    logic [IDX_W-1:0]  cmp_idx;
    logic [DATA_W-1:0] cmp_score;
    logic [IDX_W-1:0]  win_idx;
    logic [DATA_W-1:0] win_score;
    logic [IDX_W-1:0]  beat_idx;
    logic              first_beat;
    logic              last_beat;
    logic              drop;

`ifdef MNIST_ARGMAX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout_hit;

    assign timeout_hit = (state == ST_ACCUM) && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));

    // Idle gap counter only runs while a frame is partially received.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (frame_start || timeout_hit || logit_valid || (state != ST_ACCUM)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (frame_start) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end
    end

    assign drop = frame_start || timeout_hit;
`else
    assign err  = 1'b0;
    assign drop = frame_start;
`endif

    // A beat after a drop or from IDLE restarts the frame at index 0.
    assign first_beat = drop || (state == ST_IDLE);
    assign beat_idx   = first_beat ? '0 : cnt;
    assign last_beat  = (beat_idx == LAST_IDX);

    mnist_signed_max_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .best_score (best_score),
        .best_idx   (best_idx),
        .cand_score (logit_in),
        .cand_idx   (cnt),
        .next_score (cmp_score),
        .next_idx   (cmp_idx)
    );

    assign win_score = first_beat ? logit_in : cmp_score;
    assign win_idx   = first_beat ? '0       : cmp_idx;

    assign busy = (state == ST_ACCUM);

    // Later assignments win: an accepted beat overrides the drop's return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            best_score  <= '0;
            best_idx    <= '0;
            class_idx   <= '0;
            class_score <= '0;
            class_valid <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            class_valid <= 1'b0;
            if (drop) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end
            if (logit_valid) begin
                best_score <= win_score;
                best_idx   <= win_idx;
                if (last_beat) begin
                    class_idx   <= win_idx;
                    class_score <= win_score;
                    class_valid <= 1'b1;
                    frame_cnt   <= frame_cnt + CNT_W'(1);
                    state       <= ST_IDLE;
                    cnt         <= '0;
                end else begin
                    state <= ST_ACCUM;
                    cnt   <= beat_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/mnist_argmax_classifier.md
Name: mnist_argmax_classifier

Overview:
- Downstream stage of the MNIST network core.
- Consumes the serial stream of NUM_CLASSES signed 32-bit logits produced by the FC2 layer, one per valid beat, and tracks the running maximum.
- After the last logit it emits the winning class index and its score with a one-cycle valid pulse.
- Feeds the board-level result display/UART path; the core has no backpressure, so this block must accept one logit per cycle.

Parameters:
- NUM_CLASSES, 10, logits per image.
- DATA_W, 32, logit width (two's complement).
- IDX_W, 4, class index width; must satisfy 2**IDX_W >= NUM_CLASSES.
- CNT_W, 16, width of the completed-image counter.
- TIMEOUT_CYCLES, 1024, maximum idle gap inside a frame (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- logit_valid  in  1  logit_in valid this cycle; no ready, always accepted.
- logit_in  in  DATA_W  signed logit from the network core.
- frame_start  in  1  pulse; discards any partial frame and resynchronises.
- class_idx  out  IDX_W  winning class, held until next result.
- class_score  out  DATA_W  winning logit, held.
- class_valid  out  1  one-cycle pulse when class_idx/class_score update.
- busy  out  1  high while a frame is partially received.
- frame_cnt  out  CNT_W  completed classifications, wraps.
- err  out  1  sticky frame error flag, cleared by frame_start or rst.

Behaviour:
- Reset (async, active-high): all outputs are 0, the beat counter is 0, the state is IDLE, and best_score/best_idx are 0.
- States:
  - IDLE: busy=0. A logit_valid beat becomes beat 0: best_score<=logit_in, best_idx<=0, cnt<=1, go to ACCUM.
  - ACCUM: busy=1. On each logit_valid beat at beat index k, replace the best if logit_in > best_score (signed, strict). Ties keep the lower index.
  - Final beat (k = NUM_CLASSES-1): on the next clock edge, class_idx/class_score <= final winner (including this beat), class_valid <= 1 for exactly one cycle, frame_cnt increments (wraps at 2**CNT_W), return to IDLE.
- Latency: class_valid rises on the cycle after the final logit_valid beat.
- Back-to-back frames: a logit_valid in the cycle class_valid is high is beat 0 of the next frame. No bubble is required.
- Gaps: logit_valid may be low for any number of cycles inside a frame; the state holds.
- frame_start: highest priority. cnt<=0, err<=0, state<=IDLE. If logit_valid is high in the same cycle, that logit is taken as beat 0 of the new frame.
  - If frame_start arrives while ACCUM, no result is emitted and frame_cnt is unchanged.
  - If frame_start coincides with the final beat, the final beat is discarded and there is no class_valid.
- NUM_CLASSES==1: every beat immediately yields class_valid with idx 0.
- Comparison is full DATA_W signed. No saturation or truncation. class_score is the exact input value.
- Mid-operation reset: behaves as power-on reset. No class_valid is emitted for the interrupted frame.

Optional Feature:
- Macro: MNIST_ARGMAX_TIMEOUT_EN.
- Defined:
  - An idle counter runs in ACCUM and clears on each logit_valid.
  - When it reaches TIMEOUT_CYCLES with no beat, the partial frame is dropped: state<=IDLE, err<=1 (sticky), no class_valid, frame_cnt unchanged.
  - A beat arriving in the expiry cycle is taken as beat 0 of a new frame.
- Undefined: no idle counter, no TIMEOUT_CYCLES logic. err is tied 0 (port retained). ACCUM waits indefinitely.

Decomposition:
- Shared package mnist_pkg:
  - NUM_CLASSES, DATA_W, IDX_W constants.
  - State encoding localparams ST_IDLE/ST_ACCUM.
- One natural sub-module: mnist_signed_max_cmp.
  - Combinational signed strict-greater comparator plus mux, returning next best_score/best_idx.
  - Reused by later top-k work.
- Counters and FSM stay in this module.

Test Plan:
- Reset, then logits 5,-3,12,7,0,1,2,3,4,-100 on consecutive cycles -> class_valid one cycle after the 10th beat; class_idx=2, class_score=12, frame_cnt=1, busy low afterwards.
- All logits -7 (equal) -> class_idx=0, class_score=-7 (tie keeps lowest index). Max at last position: logits 0..8 = -1, logit 9 = 0x7FFFFFFF -> class_idx=9, class_score=2147483647.
- Signed check: logit 0 = 0x80000000, logit 3 = 1, others 0x80000000 -> class_idx=3. Two frames back-to-back with no gap -> two class_valid pulses exactly 10 cycles apart, frame_cnt=2.
- Gaps: beats with 0-5 random idle cycles between them, max at index 6 = 100 -> class_idx=6. frame_start after 4 beats, then a full frame with max at index 1 -> exactly one class_valid, class_idx=1, frame_cnt=1.
- frame_start and logit_valid in the same cycle as the 10th beat -> no class_valid that cycle. The beat becomes beat 0 of a new frame, and a result follows 9 beats later. Assert rst in the middle of a frame -> outputs are 0 immediately (asynchronous).
- With MNIST_ARGMAX_TIMEOUT_EN and TIMEOUT_CYCLES=16: 3 beats then 16 idle cycles -> err=1, no class_valid. Next full frame classifies normally; err stays 1 until frame_start.
